// File: rtl/sap_out_serializer.sv
// sap_out_serializer: buffers every LO-strobed OUT value in a FIFO and ships each one
// as an async serial frame (start, 9 data bits LSB-first, stop) on TX.
module sap_out_serializer #(
   parameter int CLKS_PER_BIT = 4,
   parameter int DEPTH        = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     LO,
   input  logic [8:0]               OUT_IN,
   input  logic                     CLR_OVF,
   output logic                     TX,
   output logic                     BUSY,
   output logic                     EMPTY,
   output logic                     FULL,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic                     OVF
);
   localparam int PW  = $clog2(DEPTH);
   localparam int CNW = PW + 1;
   localparam int CW  = $clog2(CLKS_PER_BIT);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [3:0]    bit_idx;
   logic [8:0]    shift;
   logic [8:0]    mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic          pop, wr, accept, bit_end;
   assign pop     = (state == IDLE) && !EMPTY;
   assign wr      = !LO;
   // a pop at the same edge frees a slot, so a write into a full FIFO still lands
   assign accept  = wr && (!FULL || pop);
   assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
   assign EMPTY   = COUNT == '0;
   assign FULL    = COUNT == CNW'(DEPTH);
   always_ff @(posedge clk)
      if (accept) mem[wr_ptr] <= OUT_IN;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         COUNT   <= '0;
         OVF     <= 1'b0;
         TX      <= 1'b1;
         BUSY    <= 1'b0;
      end else begin
         wr_ptr <= accept ? wr_ptr + PW'(1) : wr_ptr;
         rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
         COUNT  <= COUNT + CNW'(accept) - CNW'(pop);
         OVF    <= (wr && !accept) || (OVF && !CLR_OVF);
         cnt    <= (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
         case (state)
            IDLE:
               if (pop) begin
                  state <= START;
                  shift <= mem[rd_ptr];
                  TX    <= 1'b0;
                  BUSY  <= 1'b1;
               end
            START:
               if (bit_end) begin
                  state   <= DATA;
                  bit_idx <= '0;
                  TX      <= shift[0];
               end
            DATA:
               if (bit_end) begin
                  if (bit_idx == 4'd8) begin
                     state <= STOP;
                     TX    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                     shift   <= shift >> 1;
                     TX      <= shift[1];
                  end
               end
            STOP:
               if (bit_end) begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_sap_out_serializer.sv
// tb_sap_out_serializer: directed checks of capture, FIFO, overflow and serial framing.
module tb_sap_out_serializer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       LO = 1'b1;
   logic [8:0] OUT_IN = '0;
   logic       CLR_OVF = 1'b0;
   logic       TX, BUSY, EMPTY, FULL, OVF;
   logic [2:0] COUNT;
   int n_chk = 0, n_err = 0;
   int cyc = 0;
   logic [10:0] rxq[$];
   int          tq[$];

   sap_out_serializer #(.CLKS_PER_BIT(4), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .LO(LO), .OUT_IN(OUT_IN), .CLR_OVF(CLR_OVF),
      .TX(TX), .BUSY(BUSY), .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT), .OVF(OVF));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // independent line receiver: samples each bit at its centre, frame word = {stop, data, start}
   initial forever begin
      logic [10:0] f;
      int          t;
      @(posedge clk); #2;
      if (rst && TX === 1'b0) begin
         t = cyc;
         repeat (2) @(posedge clk);
         #2 f[0] = TX;
         for (int j = 1; j < 11; j++) begin
            repeat (4) @(posedge clk);
            #2 f[j] = TX;
         end
         rxq.push_back(f);
         tq.push_back(t);
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wr1(input logic [8:0] v);
      LO = 1'b0; OUT_IN = v;
      tick();
      LO = 1'b1;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int k = 0;
      while (rxq.size() < n && k < budget) begin tick(); k++; end
      chk("frames_timeout", rxq.size() >= n, 1);
   endtask

   initial begin
      int n, maxc, t0;
      logic [8:0] exp_q[$];
      logic [8:0] v;
      repeat (3) tick();
      chk("rst_tx", TX, 1); chk("rst_busy", BUSY, 0); chk("rst_count", COUNT, 0);
      chk("rst_empty", EMPTY, 1); chk("rst_full", FULL, 0); chk("rst_ovf", OVF, 0);
      rst = 1'b1;
      repeat (2) tick();

      // single result 9'h004
      wr1(9'h004);
      chk("single_count1", COUNT, 1); chk("single_tx_idle", TX, 1); chk("single_busy0", BUSY, 0);
      tick();
      chk("single_tx_fall", TX, 0); chk("single_busy1", BUSY, 1); chk("single_count0", COUNT, 0);
      n = 0;
      while (BUSY && n < 200) begin n++; tick(); end
      chk("single_busy_len", n, 44);
      wait_frames(1, 50);
      chk("single_frame", rxq.pop_front(), {1'b1, 9'h004, 1'b0});
      void'(tq.pop_front());
      repeat (5) tick();

      // burst of three
      maxc = 0;
      wr1(9'h1FF); if (COUNT > maxc) maxc = COUNT;
      LO = 1'b0; OUT_IN = 9'h000; tick(); if (COUNT > maxc) maxc = COUNT;
      OUT_IN = 9'h155; tick(); if (COUNT > maxc) maxc = COUNT;
      LO = 1'b1;
      n = 0;
      while (rxq.size() < 3 && n < 300) begin tick(); n++; if (COUNT > maxc) maxc = COUNT; end
      chk("burst_timeout", rxq.size(), 3);
      chk("burst_peak", maxc, 2);
      chk("burst_f0", rxq[0], {1'b1, 9'h1FF, 1'b0});
      chk("burst_f1", rxq[1], {1'b1, 9'h000, 1'b0});
      chk("burst_f2", rxq[2], {1'b1, 9'h155, 1'b0});
      chk("burst_gap01", tq[1] - tq[0], 45);
      chk("burst_gap12", tq[2] - tq[1], 45);
      rxq.delete(); tq.delete();
      repeat (10) tick();

      // overflow while a frame is in flight
      wr1(9'h100);
      tick();
      chk("ovf_busy", BUSY, 1);
      for (int i = 1; i <= 6; i++) wr1(9'(i));
      chk("ovf_count", COUNT, 4); chk("ovf_full", FULL, 1); chk("ovf_set", OVF, 1);
      CLR_OVF = 1'b1; tick(); CLR_OVF = 1'b0;
      chk("ovf_clr", OVF, 0);

      // write into full FIFO on the edge where IDLE pops
      n = 0;
      while (BUSY && n < 100) begin tick(); n++; end
      chk("stop_timeout", BUSY, 0);
      chk("pre_pop_full", FULL, 1);
      wr1(9'h0AA);
      chk("wp_count", COUNT, 4); chk("wp_ovf", OVF, 0); chk("wp_busy", BUSY, 1);
      wait_frames(6, 400);
      repeat (60) tick();
      chk("ovf_nframes", rxq.size(), 6);
      exp_q = '{9'h100, 9'h001, 9'h002, 9'h003, 9'h004, 9'h0AA};
      foreach (exp_q[i]) chk($sformatf("ovf_f%0d", i), rxq[i], {1'b1, exp_q[i], 1'b0});
      chk("drain_empty", EMPTY, 1);
      rxq.delete(); tq.delete();

      // pointer wrap: ten spaced writes
      maxc = 0;
      for (int i = 0; i < 10; i++) begin
         v = 9'(i * 37 + 3);
         wr1(v);
         if (COUNT > maxc) maxc = COUNT;
         for (int k = 0; k < 49; k++) begin tick(); if (COUNT > maxc) maxc = COUNT; end
      end
      wait_frames(10, 100);
      chk("wrap_maxcount", maxc, 1);
      for (int i = 0; i < 10; i++)
         chk($sformatf("wrap_f%0d", i), (rxq.size() > i) ? int'(rxq[i]) : -1,
             {1'b1, 9'(i * 37 + 3), 1'b0});

      // asynchronous reset mid-DATA with data still queued
      wr1(9'h000);
      wr1(9'h0FF);
      repeat (10) tick();
      chk("mid_tx_low", TX, 0); chk("mid_count", COUNT, 1);
      t0 = cyc;
      rst = 1'b0;
      #1;
      chk("arst_tx", TX, 1); chk("arst_count", COUNT, 0); chk("arst_busy", BUSY, 0);
      chk("arst_async", cyc - t0, 0);
      tick();
      rst = 1'b1;
      repeat (3) tick();
      chk("post_rst_tx", TX, 1); chk("post_rst_empty", EMPTY, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
